// File: rtl/dds_pkg.sv
// Shared types and constants for the DDS sweep scheduler and the DDS datapath it drives.
// No timing of its own; no backpressure.
package dds_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } sweep_state_e;

  localparam int DDS_ACC_W   = 24;
  localparam int DDS_LUT_AW  = 16;

  localparam int DEF_FREQ_W  = 32;
  localparam int DEF_DWELL_W = 32;
  localparam int DEF_IDX_W   = 16;

endpackage

// File: rtl/sweep_dwell_cnt.sv
// Loadable dwell down-counter: load wins over hold, stops at zero; zero is registered-count compare.
// Load/decrement take effect on the next edge; no backpressure.
module sweep_dwell_cnt
  import dds_pkg::*;
#(
  parameter int W = DEF_DWELL_W
) (
  input  logic         DAC_clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         hold,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (!hold && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge DAC_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Stepped-sweep / frequency-hop scheduler driving DDS FreqCntrl and en; all outputs registered,
// Start seen at edge N is reflected right after edge N. No backpressure: Abort > Hold > dwell/step.
module dds_sweep_ctrl
  import dds_pkg::*;
#(
  parameter int FREQ_W  = DEF_FREQ_W,
  parameter int DWELL_W = DEF_DWELL_W,
  parameter int IDX_W   = DEF_IDX_W
) (
  input  logic               DAC_clk,
  input  logic               rst_n,
  input  logic               Start,
  input  logic               Abort,
  input  logic               Hold,
  input  logic               Continuous,
  input  logic               PhaseSync,
  input  logic [FREQ_W-1:0]  FreqStart,
  input  logic [FREQ_W-1:0]  FreqStep,
  input  logic [IDX_W-1:0]   StepCount,
  input  logic [DWELL_W-1:0] DwellCycles,
  output logic [FREQ_W-1:0]  FreqCntrl,
  output logic               DdsEn,
  output logic               Busy,
  output logic               Done,
  output logic [IDX_W-1:0]   StepIndex
);

  sweep_state_e state_q, state_d;

  logic [FREQ_W-1:0]  freq_q, freq_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               en_q, en_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // Shadow copy of the configuration, frozen for the whole sweep.
  logic [FREQ_W-1:0]  fstart_q, fstart_d;
  logic [FREQ_W-1:0]  fstep_q, fstep_d;
  logic [IDX_W-1:0]   last_idx_q, last_idx_d;
  logic [DWELL_W-1:0] reload_q, reload_d;
  logic               cont_q, cont_d;
  logic               psync_q, psync_d;

  logic               cnt_load;
  logic               cnt_hold;
  logic [DWELL_W-1:0] cnt_load_val;
  logic               cnt_zero;

  sweep_dwell_cnt #(
    .W (DWELL_W)
  ) u_dwell (
    .DAC_clk  (DAC_clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .hold     (cnt_hold),
    .load_val (cnt_load_val),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d      = state_q;
    freq_d       = freq_q;
    idx_d        = idx_q;
    en_d         = en_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    fstart_d     = fstart_q;
    fstep_d      = fstep_q;
    last_idx_d   = last_idx_q;
    reload_d     = reload_q;
    cont_d       = cont_q;
    psync_d      = psync_q;
    cnt_load     = 1'b0;
    cnt_hold     = 1'b1;
    cnt_load_val = reload_q;

    unique case (state_q)
      IDLE: begin
        if (Start && !Abort) begin
          state_d      = RUN;
          fstart_d     = FreqStart;
          fstep_d      = FreqStep;
          last_idx_d   = (StepCount == '0) ? '0 : StepCount - IDX_W'(1);
          reload_d     = (DwellCycles == '0) ? '0 : DwellCycles - DWELL_W'(1);
          cont_d       = Continuous;
          psync_d      = PhaseSync;
          freq_d       = FreqStart;
          idx_d        = '0;
          busy_d       = 1'b1;
          en_d         = !PhaseSync;
          cnt_load     = 1'b1;
          cnt_load_val = (DwellCycles == '0) ? '0 : DwellCycles - DWELL_W'(1);
        end
      end
      RUN: begin
        if (Abort) begin
          state_d = IDLE;
          en_d    = 1'b0;
          busy_d  = 1'b0;
        end else if (Hold) begin
          en_d = 1'b1;
        end else if (!cnt_zero) begin
          cnt_hold = 1'b0;
          en_d     = 1'b1;
        end else if (idx_q != last_idx_q) begin
          freq_d   = freq_q + fstep_q;
          idx_d    = idx_q + IDX_W'(1);
          cnt_load = 1'b1;
          en_d     = !psync_q;
        end else if (cont_q) begin
          freq_d   = fstart_q;
          idx_d    = '0;
          cnt_load = 1'b1;
          en_d     = !psync_q;
        end else begin
          state_d = IDLE;
          en_d    = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge DAC_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      freq_q     <= '0;
      idx_q      <= '0;
      en_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      fstart_q   <= '0;
      fstep_q    <= '0;
      last_idx_q <= '0;
      reload_q   <= '0;
      cont_q     <= 1'b0;
      psync_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      freq_q     <= freq_d;
      idx_q      <= idx_d;
      en_q       <= en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      fstart_q   <= fstart_d;
      fstep_q    <= fstep_d;
      last_idx_q <= last_idx_d;
      reload_q   <= reload_d;
      cont_q     <= cont_d;
      psync_q    <= psync_d;
    end
  end

  assign FreqCntrl = freq_q;
  assign DdsEn     = en_q;
  assign Busy      = busy_q;
  assign Done      = done_q;
  assign StepIndex = idx_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Self-checking bench for dds_sweep_ctrl: per-cycle expected output trace queued at stimulus time,
// compared on the falling edge after each active edge.
module tb_dds_sweep_ctrl;

  logic        DAC_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        Start = 1'b0;
  logic        Abort = 1'b0;
  logic        Hold = 1'b0;
  logic        Continuous = 1'b0;
  logic        PhaseSync = 1'b0;
  logic [31:0] FreqStart = '0;
  logic [31:0] FreqStep = '0;
  logic [15:0] StepCount = '0;
  logic [31:0] DwellCycles = '0;
  logic [31:0] FreqCntrl;
  logic        DdsEn;
  logic        Busy;
  logic        Done;
  logic [15:0] StepIndex;

  dds_sweep_ctrl #(
    .FREQ_W  (32),
    .DWELL_W (32),
    .IDX_W   (16)
  ) dut (
    .DAC_clk     (DAC_clk),
    .rst_n       (rst_n),
    .Start       (Start),
    .Abort       (Abort),
    .Hold        (Hold),
    .Continuous  (Continuous),
    .PhaseSync   (PhaseSync),
    .FreqStart   (FreqStart),
    .FreqStep    (FreqStep),
    .StepCount   (StepCount),
    .DwellCycles (DwellCycles),
    .FreqCntrl   (FreqCntrl),
    .DdsEn       (DdsEn),
    .Busy        (Busy),
    .Done        (Done),
    .StepIndex   (StepIndex)
  );

  always #5 DAC_clk = ~DAC_clk;

  typedef struct packed {
    logic [31:0] freq;
    logic        en;
    logic        busy;
    logic        done;
    logic [15:0] idx;
  } obs_t;

  obs_t obs;
  obs_t exp_o;
  obs_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  assign obs = {FreqCntrl, DdsEn, Busy, Done, StepIndex};

  // Expected trace built from the sweep definition: frequency s holds for D cycles, en low on
  // the first cycle of each dwell under PhaseSync; a Hold repeats the previous cycle with en high.
  task automatic push_sweep(input logic [31:0] fs, input logic [31:0] st, input int sc,
                            input int dw, input bit psync, input int passes, input bit single,
                            input int hold_at, input int hold_len);
    int   nsteps;
    int   ndwell;
    int   k;
    obs_t o;
    obs_t last;
    nsteps = (sc == 0) ? 1 : sc;
    ndwell = (dw == 0) ? 1 : dw;
    k = 0;
    last = '0;
    for (int p = 0; p < passes; p++) begin
      for (int s = 0; s < nsteps; s++) begin
        for (int d = 0; d < ndwell; d++) begin
          o.freq = fs + st * 32'(s);
          o.en   = !(psync && (d == 0));
          o.busy = 1'b1;
          o.done = 1'b0;
          o.idx  = 16'(s);
          if (k == hold_at) begin
            for (int h = 0; h < hold_len; h++) begin
              last.en = 1'b1;
              sb.push_back(last);
            end
          end
          sb.push_back(o);
          last = o;
          k++;
        end
      end
    end
    if (single) begin
      o = last;
      o.en = 1'b0;
      o.busy = 1'b0;
      o.done = 1'b1;
      sb.push_back(o);
      o.done = 1'b0;
      sb.push_back(o);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    vectors++;
    if (obs !== '0) begin
      $display("FAIL reset_state: got %p want all zero", obs);
      miscompares++;
    end
    @(negedge DAC_clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge DAC_clk);
      vectors++;
      if (obs !== '0) begin
        $display("FAIL reset_idle cycle %0d: got %p want all zero", i, obs);
        miscompares++;
      end
    end
    FreqStart = 32'h0000_4000; FreqStep = 32'h0000_0040; StepCount = 16'd4; DwellCycles = 32'd3;
    Start = 1'b1;
    push_sweep(32'h0000_4000, 32'h0000_0040, 4, 3, 1'b0, 1, 1'b1, -1, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge DAC_clk);
      exp_o = sb.pop_front();
      vectors++;
      if (obs !== exp_o) begin
        $display("FAIL pre_reset_run cycle %0d: got %p want %p", i, obs, exp_o);
        miscompares++;
      end
      Start = 1'b0;
    end
    sb.delete();
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (obs !== '0) begin
      $display("FAIL reset_async_mid_sweep: got %p want all zero", obs);
      miscompares++;
    end
    @(negedge DAC_clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge DAC_clk);
      vectors++;
      if (obs !== '0) begin
        $display("FAIL post_reset_idle cycle %0d: got %p want all zero", i, obs);
        miscompares++;
      end
    end
  endtask

  task automatic test_single_pass();
    FreqStart = 32'h0000_1000; FreqStep = 32'h0000_0100; StepCount = 16'd4; DwellCycles = 32'd3;
    Continuous = 1'b0; PhaseSync = 1'b0;
    Start = 1'b1;
    push_sweep(32'h0000_1000, 32'h0000_0100, 4, 3, 1'b0, 1, 1'b1, -1, 0);
    for (int i = 0; sb.size() > 0; i++) begin
      @(negedge DAC_clk);
      exp_o = sb.pop_front();
      vectors++;
      if (obs !== exp_o) begin
        $display("FAIL single_pass cycle %0d: got %p want %p", i, obs, exp_o);
        miscompares++;
      end
      Start = 1'b0;
    end
  endtask

  task automatic test_continuous_wrap();
    obs_t ab;
    FreqStart = 32'h0; FreqStep = 32'hFFFF_FF00; StepCount = 16'd3; DwellCycles = 32'd2;
    Continuous = 1'b1; PhaseSync = 1'b0;
    Start = 1'b1;
    push_sweep(32'h0, 32'hFFFF_FF00, 3, 2, 1'b0, 2, 1'b0, -1, 0);
    ab = '{freq: 32'hFFFF_FE00, en: 1'b0, busy: 1'b0, done: 1'b0, idx: 16'd2};
    for (int i = 0; sb.size() > 0; i++) begin
      @(negedge DAC_clk);
      exp_o = sb.pop_front();
      vectors++;
      if (obs !== exp_o) begin
        $display("FAIL continuous cycle %0d: got %p want %p", i, obs, exp_o);
        miscompares++;
      end
      Start = 1'b0;
    end
    Abort = 1'b1;
    Continuous = 1'b0;
    sb.push_back(ab);
    sb.push_back(ab);
    for (int i = 0; sb.size() > 0; i++) begin
      @(negedge DAC_clk);
      exp_o = sb.pop_front();
      vectors++;
      if (obs !== exp_o) begin
        $display("FAIL abort cycle %0d: got %p want %p", i, obs, exp_o);
        miscompares++;
      end
      Abort = 1'b0;
    end
  endtask

  task automatic test_phasesync_hold();
    FreqStart = 32'h0000_2000; FreqStep = 32'h0000_0010; StepCount = 16'd3; DwellCycles = 32'd4;
    Continuous = 1'b0; PhaseSync = 1'b1;
    Start = 1'b1;
    push_sweep(32'h0000_2000, 32'h0000_0010, 3, 4, 1'b1, 1, 1'b1, 6, 5);
    for (int i = 0; sb.size() > 0; i++) begin
      @(negedge DAC_clk);
      exp_o = sb.pop_front();
      vectors++;
      if (obs !== exp_o) begin
        $display("FAIL phasesync_hold cycle %0d: got %p want %p", i, obs, exp_o);
        miscompares++;
      end
      Start = 1'b0;
      Hold = (i >= 5) && (i < 10);
    end
    Hold = 1'b0;
    PhaseSync = 1'b0;
  endtask

  task automatic test_degenerate();
    FreqStart = 32'h0000_0ABC; FreqStep = 32'h0000_0111; StepCount = 16'd0; DwellCycles = 32'd0;
    Start = 1'b1;
    push_sweep(32'h0000_0ABC, 32'h0000_0111, 0, 0, 1'b0, 1, 1'b1, -1, 0);
    for (int i = 0; sb.size() > 0; i++) begin
      @(negedge DAC_clk);
      exp_o = sb.pop_front();
      vectors++;
      if (obs !== exp_o) begin
        $display("FAIL degenerate cycle %0d: got %p want %p", i, obs, exp_o);
        miscompares++;
      end
      Start = 1'b0;
    end
  endtask

  task automatic test_simultaneous();
    obs_t idle;
    idle = '{freq: 32'h0000_0ABC, en: 1'b0, busy: 1'b0, done: 1'b0, idx: 16'd0};
    FreqStart = 32'h0000_5000; FreqStep = 32'h0000_0800; StepCount = 16'd2; DwellCycles = 32'd3;
    Start = 1'b1;
    Abort = 1'b1;
    sb.push_back(idle);
    sb.push_back(idle);
    for (int i = 0; sb.size() > 0; i++) begin
      @(negedge DAC_clk);
      exp_o = sb.pop_front();
      vectors++;
      if (obs !== exp_o) begin
        $display("FAIL start_abort_idle cycle %0d: got %p want %p", i, obs, exp_o);
        miscompares++;
      end
      Start = 1'b0;
      Abort = 1'b0;
    end
    Start = 1'b1;
    push_sweep(32'h0000_5000, 32'h0000_0800, 2, 3, 1'b0, 1, 1'b1, -1, 0);
    for (int i = 0; sb.size() > 0; i++) begin
      @(negedge DAC_clk);
      exp_o = sb.pop_front();
      vectors++;
      if (obs !== exp_o) begin
        $display("FAIL start_while_busy cycle %0d: got %p want %p", i, obs, exp_o);
        miscompares++;
      end
      Start = (i == 1) || (i == 5);
      if (i == 0) begin
        FreqStart = 32'h0000_DEAD;
        DwellCycles = 32'd7;
      end
    end
    Start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_pass();
    test_continuous_wrap();
    test_phasesync_hold();
    test_degenerate();
    test_simultaneous();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dds_sweep_ctrl.md
# dds_sweep_ctrl

Frequency-hop / stepped-sweep scheduler that sequences the DDS block. It drives the DDS `FreqCntrl` word and `en` input, stepping through a programmed list of equally spaced frequencies. Each frequency is held for an exact number of `DAC_clk` cycles. Configuration comes from AXI registers, already synchronised into the `DAC_clk` domain; this block runs entirely in `DAC_clk`.

## Interface
Parameters:
- `FREQ_W`, default 32: width of frequency words (the DDS uses bits [23:0]).
- `DWELL_W`, default 32: width of the dwell counter.
- `IDX_W`, default 16: width of the step index / step count.

Ports:
- `DAC_clk` in 1: the only clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `Start` in 1: one-cycle request to begin a sweep.
- `Abort` in 1: stop immediately; highest priority.
- `Hold` in 1: freeze the sweep at the current step while high.
- `Continuous` in 1: 1 = loop forever; 0 = single pass.
- `PhaseSync` in 1: 1 = force DDS accumulator restart at every hop.
- `FreqStart` in FREQ_W: first frequency word.
- `FreqStep` in FREQ_W: increment per hop, two's complement (negative values sweep down).
- `StepCount` in IDX_W: number of frequencies per pass. 0 is treated as 1.
- `DwellCycles` in DWELL_W: cycles per frequency. 0 is treated as 1.
- `FreqCntrl` out FREQ_W: to DDS `FreqCntrl`.
- `DdsEn` out 1: to DDS `en`.
- `Busy` out 1: sweep active.
- `Done` out 1: one-cycle pulse at the end of a single-pass sweep.
- `StepIndex` out IDX_W: index of the current frequency.

## Operation
- FSM has two states, IDLE and RUN. All outputs are registered.
- Reset values: `FreqCntrl`=0, `DdsEn`=0, `Busy`=0, `Done`=0, `StepIndex`=0, state IDLE, dwell counter 0.
- Configuration inputs are latched into shadow registers on an accepted `Start`. Changes to the inputs while `Busy` are ignored until the next start.
- **IDLE:**
  - `Start`=1 and `Abort`=0 → RUN.
  - On the same edge: `FreqCntrl`←`FreqStart`, `StepIndex`←0, `Busy`←1, `DdsEn`←1 (or ←0 if `PhaseSync`), dwell counter←max(`DwellCycles`,1)−1.
- **RUN, dwell counter ≠ 0:**
  - Counter decrements by 1.
  - `DdsEn`←1.
- **RUN, dwell counter = 0, not last step:**
  - `FreqCntrl`←`FreqCntrl`+`FreqStep` (mod 2^FREQ_W, silent wrap).
  - `StepIndex`+1.
  - Counter reloaded.
  - `DdsEn`←0 if `PhaseSync`, else 1.
- **RUN, dwell counter = 0, last step** (`StepIndex` = max(`StepCount`,1)−1):
  - `Continuous`=1: `FreqCntrl`←`FreqStart`, `StepIndex`←0, counter reloaded; same `PhaseSync` rule as a hop.
  - `Continuous`=0: → IDLE, `DdsEn`←0, `Busy`←0, `Done`←1 for one cycle. `FreqCntrl` and `StepIndex` hold their last values.
- **`Hold`=1 in RUN:**
  - Counter, `FreqCntrl` and `StepIndex` freeze.
  - `DdsEn` is forced to 1, so the DDS keeps running at the current frequency.
  - `Hold` is ignored in IDLE.
- **`Abort`=1, any state:**
  - Next edge: IDLE, `DdsEn`←0, `Busy`←0.
  - No `Done` pulse. `FreqCntrl` and `StepIndex` hold.
- **Simultaneous events:**
  - `Abort` beats `Start`, `Hold` and step logic.
  - `Start` while `Busy` is ignored.
  - `Start` in the same cycle as the `Done` edge is ignored (the FSM is still in RUN).

## Timing
- Start latency: `Start` sampled at edge N → new `FreqCntrl` and `DdsEn` valid after edge N.
- Each frequency is presented for exactly max(`DwellCycles`,1) cycles, including the `PhaseSync` gap cycle.
- With `PhaseSync`=1, `DdsEn` is low for the first cycle of every dwell. This zeroes the DDS accumulator, so each hop starts at phase `PhaseCntrl`.
- A dwell of 1 with `PhaseSync`=1 keeps `DdsEn` permanently low; this is legal and documented.
- Single pass with S steps and dwell D: `Busy` is high for exactly S·D cycles. `Done` is asserted on the edge `Busy` falls.
- `Hold` adds exactly one cycle of dwell per cycle it is high.
- Downstream latency (DDS accumulator, LUT, multiplier) is not compensated here.

## Structure
- Shared package `dds_pkg`:
  - state enum (IDLE, RUN);
  - constants `DDS_ACC_W`=24 and `DDS_LUT_AW`=16;
  - default widths FREQ_W, DWELL_W, IDX_W.
- One sub-module, `sweep_dwell_cnt`:
  - loadable down-counter with hold;
  - `load`, `hold`, `load_val` inputs; `zero` output.
- Top level: FSM, shadow registers, frequency adder, step index.

## Test plan
- **Reset mid-sweep:** assert `rst_n`=0 during RUN → all outputs 0 asynchronously; after release, stays IDLE with no `Start`.
- **Single pass:** `FreqStart`=0x1000, `FreqStep`=0x100, `StepCount`=4, `DwellCycles`=3 → `FreqCntrl` = 0x1000/0x1100/0x1200/0x1300, each for 3 cycles; `Busy` high 12 cycles; one `Done` pulse; `DdsEn` low afterwards.
- **Continuous with negative step and wrap:** `FreqStart`=0x0, `FreqStep`=0xFFFF_FF00, `StepCount`=3, `DwellCycles`=2 → 0x0, 0xFFFF_FF00, 0xFFFF_FE00, then back to 0x0; no `Done`; `Abort` → `DdsEn` 0 next cycle, no `Done`.
- **PhaseSync and Hold:** `PhaseSync`=1, `DwellCycles`=4 → `DdsEn` pattern 0111 per step; 5-cycle `Hold` mid-dwell → that step lasts 9 cycles with `DdsEn` high throughout the hold.
- **Degenerate config:** `StepCount`=0 and `DwellCycles`=0 → one frequency for 1 cycle, then `Done`.
- **Simultaneous events:** `Start`+`Abort` in IDLE → stays IDLE; `Start` pulsed while `Busy` → sweep timing unchanged.
